// File: rtl/rgb_pkg.sv
// Shared types for the rgb_window streaming 3x3 window generator.
package rgb_pkg;

  localparam int unsigned PIX_W = 8;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic             hsync;
    logic             vsync;
    logic             vde;
  } beat_t;

  typedef beat_t [2:0][2:0] window_t;

endpackage

// File: rtl/rgb_line_buf.sv
// One-line circular delay buffer: combinational read at the pointer, then write
// to the same address on adv, giving exactly DEPTH beats of delay.
module rgb_line_buf
  import rgb_pkg::*;
#(
  parameter int unsigned DEPTH = 800
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  adv,
  input  beat_t wr_data,
  output beat_t rd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign rd_data = mem[ptr];

  // Memory deliberately has no reset; stale contents are never exposed
  // because the fill counter masks output until both lines are refilled.
  always_ff @(posedge clk) begin
    if (adv) begin
      mem[ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_window.sv
// Streaming 3x3 RGB window generator with valid/ready handshake.
// Optional edge replication at video borders: define RGB_WINDOW_BORDER_EN.
module rgb_window
  import rgb_pkg::*;
#(
  parameter int unsigned H_TOTAL = 800
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PIX_W-1:0]            r_i,
  input  logic [PIX_W-1:0]            g_i,
  input  logic [PIX_W-1:0]            b_i,
  input  logic                        hsync_i,
  input  logic                        vsync_i,
  input  logic                        vde_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [2:0][2:0][PIX_W-1:0]  r_o,
  output logic [2:0][2:0][PIX_W-1:0]  g_o,
  output logic [2:0][2:0][PIX_W-1:0]  b_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        vde_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int unsigned FILL_MAX = 2 * H_TOTAL + 2;
  localparam int unsigned FILL_W   = $clog2(FILL_MAX + 1);

  logic              adv;
  beat_t             in_beat;
  beat_t             lb0_rd;
  beat_t             lb1_rd;
  beat_t             pix;
  window_t           win;
  logic [FILL_W-1:0] fill;

  assign ready_o = ready_i || !valid_o;
  assign adv     = valid_i && ready_o;
  assign in_beat = '{r: r_i, g: g_i, b: b_i, hsync: hsync_i, vsync: vsync_i, vde: vde_i};

  rgb_line_buf #(.DEPTH(H_TOTAL)) u_lb0 (
    .clk     (clk_i),
    .rst     (rst_i),
    .adv     (adv),
    .wr_data (in_beat),
    .rd_data (lb0_rd)
  );

  rgb_line_buf #(.DEPTH(H_TOTAL)) u_lb1 (
    .clk     (clk_i),
    .rst     (rst_i),
    .adv     (adv),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // valid_o reflects the fill level before this beat, so the first window
  // appears only once row 0 holds real data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win     <= '0;
      fill    <= '0;
      valid_o <= 1'b0;
    end else if (adv) begin
      for (int unsigned row = 0; row < 3; row++) begin
        for (int unsigned col = 0; col < 2; col++) begin
          win[row][col] <= win[row][col+1];
        end
      end
      win[2][2] <= in_beat;
      win[1][2] <= lb0_rd;
      win[0][2] <= lb1_rd;
      valid_o   <= (fill == FILL_W'(FILL_MAX));
      if (fill != FILL_W'(FILL_MAX)) begin
        fill <= fill + 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  always_comb begin
    r_o = '0;
    g_o = '0;
    b_o = '0;
    pix = '0;
    for (int unsigned row = 0; row < 3; row++) begin
      for (int unsigned col = 0; col < 3; col++) begin
        pix = win[row][col];
`ifdef RGB_WINDOW_BORDER_EN
        if (win[1][1].vde && !pix.vde) begin
          pix = win[1][1];
        end
`endif
        r_o[row][col] = pix.r;
        g_o[row][col] = pix.g;
        b_o[row][col] = pix.b;
      end
    end
  end

  assign hsync_o = win[1][1].hsync;
  assign vsync_o = win[1][1].vsync;
  assign vde_o   = win[1][1].vde;

endmodule
